// File: rtl/sdpb_burst_reader.sv
// Port-B burst read sequencer for SDPB RAMs: start to first beat 3 cycles, then 1 beat/cycle.
// Backpressure via 2-credit skid FIFO; optional abort port under macro RDR_ABORT_EN.

module sdpb_fifo #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr_vld,
   input  logic [DW-1:0] i_wr_dat,
   input  logic          i_rd_rdy,
   input  logic          i_flush,
   output logic          o_rd_vld,
   output logic [DW-1:0] o_rd_dat,
   output logic [1:0]    o_count
);
   logic [DW-1:0] r_mem [2];
   logic          r_wp;
   logic          r_rp;
   logic [1:0]    r_cnt;
   logic          w_pop;

   assign w_pop    = i_rd_rdy && (r_cnt != 2'd0);
   assign o_rd_vld = (r_cnt != 2'd0);
   assign o_rd_dat = r_mem[r_rp];
   assign o_count  = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else if (i_flush) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (i_wr_vld) begin
            r_mem[r_wp] <= i_wr_dat;
            r_wp        <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, i_wr_vld} - {1'b0, w_pop};
      end
   end
endmodule

module sdpb_burst_reader #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   len,
`ifdef RDR_ABORT_EN
   input  logic          abort,
`endif
   output logic          busy,
   output logic          done,
   output logic          ram_ceb,
   output logic          ram_oce,
   output logic [AW-1:0] ram_adb,
   input  logic [DW-1:0] ram_dout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_issue_rem;
   logic [AW:0]   r_beat_rem;
   logic          r_busy;
   logic          r_done;
   logic          r_inflight;
   logic          w_ceb;
   logic          w_pop;
   logic          w_abort;
   logic          w_start_ok;
   logic          w_last_beat;
   logic          w_fifo_vld;
   logic [1:0]    w_fifo_cnt;
   logic [2:0]    w_used;

`ifdef RDR_ABORT_EN
   assign w_abort = abort && r_busy;
`else
   assign w_abort = 1'b0;
`endif

   assign w_pop       = w_fifo_vld && m_ready;
   assign w_start_ok  = start && (r_state == S_IDLE) && !r_done;
   assign w_last_beat = w_pop && (r_beat_rem == (AW+1)'(1));
   // A word leaving the FIFO this cycle frees its credit now, so the issue
   // decision sees m_ready directly; this is what sustains one beat per cycle.
   assign w_used      = {1'b0, w_fifo_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};

   always_comb begin
      w_state_nxt = r_state;
      w_ceb       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok && (len != '0)) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_ceb = (r_issue_rem != '0) && (w_used < 3'd2);
            if (w_ceb && (r_issue_rem == (AW+1)'(1))) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_last_beat) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) begin
         w_ceb       = 1'b0;
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_issue_rem <= '0;
         r_beat_rem  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_inflight  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_ceb;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= (w_start_ok && (len == '0)) ||
                       ((r_state == S_DRAIN) && w_last_beat) || w_abort;
         if (w_start_ok) begin
            r_addr      <= start_addr;
            r_issue_rem <= len;
            r_beat_rem  <= len;
         end else begin
            if (w_ceb) begin
               r_addr      <= r_addr + AW'(1);
               r_issue_rem <= r_issue_rem - (AW+1)'(1);
            end
            if (w_pop) r_beat_rem <= r_beat_rem - (AW+1)'(1);
         end
      end
   end

   sdpb_fifo #(.DW(DW)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_vld (r_inflight && !w_abort),
      .i_wr_dat (ram_dout),
      .i_rd_rdy (m_ready),
      .i_flush  (w_abort),
      .o_rd_vld (w_fifo_vld),
      .o_rd_dat (m_data),
      .o_count  (w_fifo_cnt)
   );

   assign busy    = r_busy;
   assign done    = r_done;
   assign ram_ceb = w_ceb;
   assign ram_oce = w_ceb;
   assign ram_adb = r_addr;
   assign m_valid = w_fifo_vld;
   assign m_last  = w_fifo_vld && (r_beat_rem == (AW+1)'(1));
endmodule
